// File: rtl/req_gnt_responder.sv
// req_gnt_responder: request/grant handshake responder.
// An accepted request (cStart & req in IDLE) waits LAT cycles and is then
// granted. The grant is held for at least HOLD cycles and for as long after
// that as req stays high. A req drop while waiting aborts the request. A
// completed grant passes through a one-cycle RELEASE state and bumps a
// saturating grant counter.
// Legal parameter ranges: LAT 2..15, HOLD 1..255.
module req_gnt_responder #(
    parameter int unsigned LAT  = 2,
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cStart,
    input  logic       req,
    output logic       gnt,
    output logic       busy,
    output logic       done,
    output logic       abort,
    output logic [7:0] gnt_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // lat_cnt is loaded with LAT-1 on acceptance and counts down to 0; the
    // grant is taken on the edge where it is already 0, which puts gnt high
    // exactly LAT edges after the accepting edge.
    localparam logic [3:0] LAT_LOAD  = 4'(LAT - 1);
    // hold_cnt reaching 1 on an edge means HOLD grant cycles have elapsed.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] lat_cnt;
    logic [7:0] hold_cnt;
    logic       gnt_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       abort_nxt;

    // State register with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decision from the current state, req and the two counters.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (cStart && req) state_nxt = S_WAIT;
            S_WAIT: begin
                if (!req)                state_nxt = S_IDLE;
                else if (lat_cnt == 4'd0) state_nxt = S_GRANT;
            end
            S_GRANT:   if (hold_cnt <= 8'd1 && !req) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the transition.
    always_comb begin
        gnt_nxt   = (state_nxt == S_GRANT);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state == S_GRANT) && (state_nxt == S_RELEASE);
        abort_nxt = (state == S_WAIT)  && (state_nxt == S_IDLE);
    end

    // Latency / hold down-counters and the saturating completed-grant count.
    // NOTE: every register here is cleared by reset; there is no memory array
    // whose contents could be left unreset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_cnt  <= 4'd0;
            hold_cnt <= 8'd0;
            gnt_cnt  <= 8'd0;
        end else begin
            if (state == S_IDLE && state_nxt == S_WAIT)
                lat_cnt <= LAT_LOAD;
            else if (state == S_WAIT && lat_cnt != 4'd0)
                lat_cnt <= lat_cnt - 4'd1;

            if (state != S_GRANT && state_nxt == S_GRANT)
                hold_cnt <= HOLD_LOAD;
            else if (state == S_GRANT && hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;

            if (done_nxt && gnt_cnt != 8'hFF)
                gnt_cnt <= gnt_cnt + 8'd1;
        end
    end

    // Output registers; reset drops gnt with no done/abort pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            gnt   <= gnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            abort <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_req_gnt_responder.sv
// Testbench for req_gnt_responder: two instances (LAT=2/HOLD=4 and
// LAT=3/HOLD=1) share stimulus; each is compared every cycle against a
// transaction-level model that tracks elapsed cycles since accept/grant.
module tb_req_gnt_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cStart;
    logic       req;
    logic       gnt_a, busy_a, done_a, abort_a;
    logic       gnt_b, busy_b, done_b, abort_b;
    logic [7:0] gnt_cnt_a, gnt_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    req_gnt_responder #(.LAT(2), .HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .cStart(cStart), .req(req),
        .gnt(gnt_a), .busy(busy_a), .done(done_a), .abort(abort_a),
        .gnt_cnt(gnt_cnt_a)
    );

    req_gnt_responder #(.LAT(3), .HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .cStart(cStart), .req(req),
        .gnt(gnt_b), .busy(busy_b), .done(done_b), .abort(abort_b),
        .gnt_cnt(gnt_cnt_b)
    );

    // Reference model: phase 0 idle, 1 pending, 2 granted, 3 release.
    int lat_p  [2] = '{2, 3};
    int hold_p [2] = '{4, 1};
    int phase  [2] = '{0, 0};
    int elapsed[2] = '{0, 0};
    int held   [2] = '{0, 0};
    int cnt    [2] = '{0, 0};
    bit done_e [2] = '{1'b0, 1'b0};
    bit abort_e[2] = '{1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit cs, input bit r);
        done_e[i]  = 1'b0;
        abort_e[i] = 1'b0;
        if (!rst) begin
            phase[i] = 0;
            cnt[i]   = 0;
        end else begin
            case (phase[i])
                0: if (cs && r) begin
                    phase[i]   = 1;
                    elapsed[i] = 0;
                end
                1: if (!r) begin
                    phase[i]   = 0;
                    abort_e[i] = 1'b1;
                end else begin
                    elapsed[i]++;
                    if (elapsed[i] == lat_p[i]) begin
                        phase[i] = 2;
                        held[i]  = 0;
                    end
                end
                2: begin
                    held[i]++;
                    if (held[i] >= hold_p[i] && !r) begin
                        phase[i]  = 3;
                        done_e[i] = 1'b1;
                        if (cnt[i] < 255) cnt[i]++;
                    end
                end
                default: phase[i] = 0;
            endcase
        end
    endtask

    function automatic logic [11:0] exp_vec(input int i);
        return {phase[i] == 2, phase[i] != 0, done_e[i], abort_e[i], 8'(cnt[i])};
    endfunction

    // Drive inputs, take one clock edge, update the model, compare #1 later.
    task automatic cycle(input bit rst, input bit cs, input bit r);
        rst_n  = rst;
        cStart = cs;
        req    = r;
        @(posedge clk);
        model_step(0, rst, cs, r);
        model_step(1, rst, cs, r);
        #1;
        check("vec_a", 32'({gnt_a, busy_a, done_a, abort_a, gnt_cnt_a}), 32'(exp_vec(0)));
        check("vec_b", 32'({gnt_b, busy_b, done_b, abort_b, gnt_cnt_b}), 32'(exp_vec(1)));
    endtask

    // One complete grant for both instances in 8 cycles; the last cycle
    // presents cStart/req during RELEASE, which must be ignored.
    task automatic grant_once();
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        logic [7:0] g29;
        bit         r_rand;
        rst_n  = 1'b0;
        cStart = 1'b0;
        req    = 1'b0;

        // Reset state
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        check("rst_gnt_cnt", 32'(gnt_cnt_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);

        // Basic grant on instance a: accept at edge 0, req drops at edge 3
        g29 = 8'b0011_1100;
        for (int e = 0; e < 8; e++) begin
            cycle(1'b1, e == 0, e < 3);
            check($sformatf("r29_gnt_e%0d", e), 32'(gnt_a), 32'(g29[e]));
            if (e == 6) check("r29_done", 32'(done_a), 32'd1);
        end
        check("r29_cnt", 32'(gnt_cnt_a), 32'd1);

        // Abort while waiting: req drops at edge 2
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check("r30_abort_b", 32'(abort_b), 32'd1);
        check("r30_abort_a", 32'(abort_a), 32'd1);
        check("r30_gnt_b", 32'(gnt_b), 32'd0);
        check("r30_cnt_b", 32'(gnt_cnt_b), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        check("r30_idle_b", 32'(busy_b), 32'd0);

        // req held long after grant: gnt stays until req drops
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, 1'b1);
        check("r31_gnt_held", 32'(gnt_a), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check("r31_done_a", 32'(done_a), 32'd1);
        check("r31_gnt_off", 32'(gnt_a), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);

        // req without cStart is never accepted
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b1);
        check("r32_busy", 32'(busy_a), 32'd0);
        check("r32_gnt", 32'(gnt_a), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);

        // Reset mid-grant with gnt_cnt=5
        cycle(1'b0, 1'b0, 1'b0);
        repeat (5) grant_once();
        check("r33_cnt5", 32'(gnt_cnt_a), 32'd5);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        check("r33_in_grant", 32'(gnt_a), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        check("r33_gnt", 32'(gnt_a), 32'd0);
        check("r33_busy", 32'(busy_a), 32'd0);
        check("r33_cnt", 32'(gnt_cnt_a), 32'd0);
        check("r33_done", 32'(done_a), 32'd0);
        // First edge after reset release accepts immediately
        cycle(1'b1, 1'b1, 1'b1);
        check("r28_accept", 32'(busy_a), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Saturation over 300 back-to-back grants
        cycle(1'b0, 1'b0, 1'b0);
        repeat (300) grant_once();
        check("r34_sat_a", 32'(gnt_cnt_a), 32'd255);
        check("r34_sat_b", 32'(gnt_cnt_b), 32'd255);

        // Randomized traffic with sticky req and occasional resets
        r_rand = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 5) == 0) r_rand = ~r_rand;
            cycle($urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0, r_rand);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
